// File: rtl/uart_bus_master_pkg.sv
// Shared types and constants for the UART register-bus initiator.
// Register map follows the 16550 layout seen through an 8-bit wr/rd/addr bus.
package uart_bus_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        POLL,
        LSR_CAP,
        RD_RBR,
        RX_CAP,
        TX,
        GAP
    } state_t;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DLM  = 3'd1;
    localparam logic [2:0] ADDR_FCR  = 3'd2;
    localparam logic [2:0] ADDR_LCR  = 3'd3;
    localparam logic [2:0] ADDR_LSR  = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;

    localparam int LCR_DLAB = 7;

    // Returns {addr, data} for step idx of the five-write configuration sequence.
    function automatic logic [10:0] init_step(input logic [2:0] idx,
                                              input logic [15:0] div,
                                              input logic [7:0] lcr,
                                              input logic [7:0] fcr);
        logic [7:0] dlab;
        dlab = 8'h01 << LCR_DLAB;
        case (idx)
            3'd0:    return {ADDR_LCR, lcr | dlab};
            3'd1:    return {ADDR_DATA, div[7:0]};
            3'd2:    return {ADDR_DLM, div[15:8]};
            3'd3:    return {ADDR_LCR, lcr & ~dlab};
            default: return {ADDR_FCR, fcr};
        endcase
    endfunction

endpackage

// File: rtl/uart_bus_master_txn.sv
// Single bus transaction engine: one write, or one read whose data is captured.
// A start arriving while a strobe is still high is dropped, guaranteeing an idle bus cycle.
module uart_bus_txn (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       done,
    output logic [7:0] rdata
);

    logic rd_cap_reg;

    // Write done arrives in the idle cycle after the strobe; read done one cycle later with data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_wr     <= 1'b0;
            bus_rd     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            rd_cap_reg <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
        end else begin
            bus_wr     <= 1'b0;
            bus_rd     <= 1'b0;
            rd_cap_reg <= bus_rd;
            done       <= bus_wr | rd_cap_reg;
            if (rd_cap_reg)
                rdata <= bus_rdata;
            if (start && !bus_wr && !bus_rd) begin
                bus_wr    <= we;
                bus_rd    <= ~we;
                bus_addr  <= addr;
                bus_wdata <= we ? wdata : 8'h00;
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side UART register-bus initiator: configures the UART, then polls LSR to move bytes.
// Optional sticky line-error flags are built when UART_BUS_MASTER_ERR_EN is defined.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_fcr,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [2:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        init_done,
    output logic [3:0]  err_flags,
    input  logic        err_clr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(POLL_GAP + 2);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST    = GW'(POLL_GAP);

    state_t        state_reg;
    logic [CW-1:0] credits_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic [2:0]    init_idx_reg;
    logic          issued_reg;
    logic [15:0]   div_reg;
    logic [7:0]    lcr_reg;
    logic [7:0]    fcr_reg;
    logic          tx_ready_reg;
    logic          rx_valid_reg;
    logic [7:0]    rx_data_reg;
    logic          init_done_reg;

    logic          txn_start;
    logic          txn_we;
    logic [2:0]    txn_addr;
    logic [7:0]    txn_wdata;
    logic          txn_done;
    logic [7:0]    txn_rdata;
    logic [10:0]   init_word;
    logic [CW-1:0] credits_eff;
    logic          restart;

    assign init_word   = init_step(init_idx_reg, div_reg, lcr_reg, fcr_reg);
    assign credits_eff = txn_rdata[LSR_THRE] ? CREDIT_FULL : credits_reg;
    assign restart     = cfg_start && (state_reg == IDLE || state_reg == GAP);

    always_comb begin
        txn_start = 1'b0;
        txn_we    = 1'b0;
        txn_addr  = ADDR_DATA;
        txn_wdata = 8'h00;
        case (state_reg)
            INIT: begin
                txn_start = ~issued_reg;
                txn_we    = 1'b1;
                txn_addr  = init_word[10:8];
                txn_wdata = init_word[7:0];
            end
            POLL: begin
                txn_start = 1'b1;
                txn_addr  = ADDR_LSR;
            end
            RD_RBR: txn_start = 1'b1;
            TX: begin
                txn_start = tx_ready_reg & tx_valid;
                txn_we    = 1'b1;
                txn_wdata = tx_data;
            end
            default: ;
        endcase
    end

    uart_bus_txn u_txn (
        .clk       (clk),
        .rst       (rst),
        .start     (txn_start),
        .we        (txn_we),
        .addr      (txn_addr),
        .wdata     (txn_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .done      (txn_done),
        .rdata     (txn_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            credits_reg   <= '0;
            gap_cnt_reg   <= '0;
            init_idx_reg  <= '0;
            issued_reg    <= 1'b0;
            div_reg       <= '0;
            lcr_reg       <= '0;
            fcr_reg       <= '0;
            tx_ready_reg  <= 1'b0;
            rx_valid_reg  <= 1'b0;
            rx_data_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            gap_cnt_reg <= '0;
            if (rx_valid_reg && rx_ready)
                rx_valid_reg <= 1'b0;
            if (restart) begin
                div_reg       <= cfg_div;
                lcr_reg       <= cfg_lcr;
                fcr_reg       <= cfg_fcr;
                init_idx_reg  <= '0;
                issued_reg    <= 1'b0;
                init_done_reg <= 1'b0;
                state_reg     <= INIT;
            end else begin
                case (state_reg)
                    INIT: begin
                        if (txn_start)
                            issued_reg <= 1'b1;
                        if (txn_done) begin
                            issued_reg <= 1'b0;
                            if (init_idx_reg == 3'd4) begin
                                init_done_reg <= 1'b1;
                                credits_reg   <= '0;
                                state_reg     <= POLL;
                            end else begin
                                init_idx_reg <= init_idx_reg + 3'd1;
                            end
                        end
                    end
                    POLL: state_reg <= LSR_CAP;
                    LSR_CAP: begin
                        // Pending RX data outranks TX; credits reload only on the non-RX path.
                        if (txn_done) begin
                            if (txn_rdata[LSR_DR] && !rx_valid_reg) begin
                                state_reg <= RD_RBR;
                            end else begin
                                credits_reg <= credits_eff;
                                if (credits_eff != '0 && tx_valid) begin
                                    tx_ready_reg <= 1'b1;
                                    state_reg    <= TX;
                                end else begin
                                    state_reg <= GAP;
                                end
                            end
                        end
                    end
                    RD_RBR: state_reg <= RX_CAP;
                    RX_CAP: begin
                        if (txn_done) begin
                            rx_data_reg  <= txn_rdata;
                            rx_valid_reg <= 1'b1;
                            state_reg    <= GAP;
                        end
                    end
                    TX: begin
                        // tx_ready low inside TX means a THR write is in flight.
                        if (tx_ready_reg) begin
                            tx_ready_reg <= 1'b0;
                            if (tx_valid) begin
                                if (credits_reg != '0)
                                    credits_reg <= credits_reg - 1'b1;
                            end else begin
                                state_reg <= GAP;
                            end
                        end else if (txn_done) begin
                            if (credits_reg != '0 && tx_valid)
                                tx_ready_reg <= 1'b1;
                            else
                                state_reg <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_reg == GAP_LAST)
                            state_reg <= POLL;
                        else
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_ready  = tx_ready_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_data   = rx_data_reg;
    assign init_done = init_done_reg;

`ifdef UART_BUS_MASTER_ERR_EN
    logic [3:0] err_reg;
    logic       lsr_seen;

    assign lsr_seen = (state_reg == LSR_CAP) && txn_done;

    // A new error in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_reg <= '0;
        else if (lsr_seen)
            err_reg <= (err_clr ? 4'b0000 : err_reg) |
                       {txn_rdata[LSR_BI], txn_rdata[LSR_FE], txn_rdata[LSR_PE], txn_rdata[LSR_OE]};
        else if (err_clr)
            err_reg <= '0;
    end

    assign err_flags = err_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master against a behavioural UART register model.
// Expectations for err_flags follow UART_BUS_MASTER_ERR_EN when that macro is defined.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [7:0]  cfg_lcr = '0;
    logic [7:0]  cfg_fcr = '0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic        bus_wr;
    logic        bus_rd;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;
    logic        init_done;
    logic [3:0]  err_flags;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    // UART / source / sink model state
    logic [7:0]  lsr_val = 8'h00;
    logic [7:0]  rbr_val = 8'h00;
    logic [7:0]  tx_bytes [64];
    int          tx_idx = 0;
    int          tx_count = 0;
    logic        tx_enable = 1'b0;
    logic        src_hs;
    logic        snk_hs;
    logic [10:0] wq[$];
    int          evt[$];
    logic [7:0]  rx_q[$];
    int          rd0 = 0;
    int          rd5 = 0;
    int          proto_errs = 0;
    logic        prev_wr = 1'b0;

    uart_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_div   (cfg_div),
        .cfg_lcr   (cfg_lcr),
        .cfg_fcr   (cfg_fcr),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .init_done (init_done),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Handshakes are judged on pre-edge values; model outputs update 1 time unit after the edge.
    always @(posedge clk) begin
        src_hs = tx_valid && tx_ready;
        snk_hs = rx_valid && rx_ready;
        if (snk_hs) begin
            rx_q.push_back(rx_data);
            $display("rx handshake data=0x%02h", rx_data);
        end
        #1;
        if (src_hs)
            tx_idx++;
        tx_valid = tx_enable && (tx_idx < tx_count);
        tx_data  = (tx_idx < 64) ? tx_bytes[tx_idx] : 8'h00;
        if (bus_rd)
            bus_rdata = (bus_addr == 3'd5) ? lsr_val : rbr_val;
    end

    always @(negedge clk) begin
        if (bus_wr && bus_rd) begin
            proto_errs++;
            $display("protocol violation: bus_wr and bus_rd both high");
        end
        if (bus_wr) begin
            if (prev_wr) begin
                proto_errs++;
                $display("protocol violation: back-to-back write strobes");
            end
            wq.push_back({bus_addr, bus_wdata});
            evt.push_back(2);
            $display("bus write addr=%0d data=0x%02h", bus_addr, bus_wdata);
        end
        if (bus_rd && bus_addr == 3'd0) begin
            rd0++;
            evt.push_back(1);
            $display("bus read addr=0 (RBR)");
        end
        if (bus_rd && bus_addr == 3'd5)
            rd5++;
        prev_wr = bus_wr;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_cfg(input logic [15:0] div, input logic [7:0] lcr, input logic [7:0] fcr);
        @(negedge clk);
        cfg_div   = div;
        cfg_lcr   = lcr;
        cfg_fcr   = fcr;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic check_init(input string tag, input logic [15:0] div, input logic [7:0] lcr,
                              input logic [7:0] fcr, input logic [10:0] exp_w [5]);
        int w0;
        int n;
        w0 = wq.size();
        pulse_cfg(div, lcr, fcr);
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: init_done=%b required 1", tag, init_done);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wq.size() <= w0 + i) begin
                bad++;
                $display("FAIL %s_write%0d: missing, required addr=%0d data=0x%02h",
                         tag, i, exp_w[i][10:8], exp_w[i][7:0]);
            end else if (wq[w0+i] !== exp_w[i]) begin
                bad++;
                $display("FAIL %s_write%0d: got addr=%0d data=0x%02h required addr=%0d data=0x%02h",
                         tag, i, wq[w0+i][10:8], wq[w0+i][7:0], exp_w[i][10:8], exp_w[i][7:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        wait_cycles(3);
        outs = {bus_wr, bus_rd, bus_addr, bus_wdata, tx_ready, rx_valid, rx_data, init_done, err_flags};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got 0x%09h required 0", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(30);
        total++;
        if (wq.size() != 0 || rd5 != 0 || init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: writes=%0d lsr_reads=%0d init_done=%b required 0/0/0",
                     wq.size(), rd5, init_done);
        end
    endtask

    task automatic test_init();
        logic [10:0] e [5];
        e[0] = {3'd3, 8'h83};
        e[1] = {3'd0, 8'h45};
        e[2] = {3'd1, 8'h01};
        e[3] = {3'd3, 8'h03};
        e[4] = {3'd2, 8'h07};
        check_init("init", 16'h0145, 8'h03, 8'h07, e);
        wait_cycles(40);
        total++;
        if (wq.size() != 5 || rd5 == 0) begin
            bad++;
            $display("FAIL init_then_poll: writes=%0d lsr_reads=%0d required 5 writes and polling",
                     wq.size(), rd5);
        end
    endtask

    task automatic test_tx_credits();
        int w0;
        int n;
        w0 = wq.size();
        lsr_val   = 8'h20;
        tx_count  = 20;
        tx_enable = 1'b1;
        n = 0;
        while (wq.size() < w0 + 16 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        lsr_val = 8'h00;
        wait_cycles(100);
        total++;
        if (wq.size() != w0 + 16 || tx_idx != 16) begin
            bad++;
            $display("FAIL tx_credit_stall: writes=%0d accepted=%0d required 16/16", wq.size() - w0, tx_idx);
        end
        lsr_val = 8'h20;
        n = 0;
        while (wq.size() < w0 + 20 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        lsr_val = 8'h00;
        wait_cycles(20);
        total++;
        if (wq.size() != w0 + 20) begin
            bad++;
            $display("FAIL tx_remaining: writes=%0d required 20", wq.size() - w0);
        end
        for (int i = 0; i < 20; i++) begin
            if (wq.size() > w0 + i) begin
                total++;
                if (wq[w0+i] !== {3'd0, 8'h10 + 8'(i)}) begin
                    bad++;
                    $display("FAIL tx_byte%0d: got addr=%0d data=0x%02h required addr=0 data=0x%02h",
                             i, wq[w0+i][10:8], wq[w0+i][7:0], 8'h10 + 8'(i));
                end
            end
        end
        tx_enable = 1'b0;
    endtask

    task automatic test_rx_hold();
        int r0;
        int n;
        r0 = rd0;
        rx_ready = 1'b0;
        rbr_val  = 8'hA5;
        lsr_val  = 8'h21;
        n = 0;
        while (!rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            bad++;
            $display("FAIL rx_first: rx_valid=%b rx_data=0x%02h required 1/0xa5", rx_valid, rx_data);
        end
        wait_cycles(100);
        total++;
        if (rd0 - r0 != 1 || rx_valid !== 1'b1) begin
            bad++;
            $display("FAIL rx_hold: rbr_reads=%0d rx_valid=%b required 1/1", rd0 - r0, rx_valid);
        end
        rbr_val  = 8'h5A;
        rx_ready = 1'b1;
        n = 0;
        while (rx_q.size() < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        lsr_val = 8'h00;
        wait_cycles(30);
        rx_ready = 1'b0;
        total++;
        if (rx_q.size() < 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h5A) begin
            bad++;
            $display("FAIL rx_sequence: received=%0d first=0x%02h second=0x%02h required 0xa5,0x5a",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, (rx_q.size() > 1) ? rx_q[1] : 8'h00);
        end
        total++;
        if (rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL rx_drained: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_rx_priority();
        int w0;
        int e0;
        int n;
        @(negedge clk);
        w0 = wq.size();
        e0 = evt.size();
        rx_ready  = 1'b0;
        rbr_val   = 8'h3C;
        tx_count  = 23;
        tx_enable = 1'b1;
        lsr_val   = 8'h21;
        n = 0;
        while (wq.size() < w0 + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        lsr_val = 8'h00;
        total++;
        if (evt.size() <= e0 || evt[e0] != 1) begin
            bad++;
            $display("FAIL rx_before_tx: first event=%0d required 1 (RBR read)",
                     (evt.size() > e0) ? evt[e0] : 0);
        end
        total++;
        if (wq.size() != w0 + 3 || rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            bad++;
            $display("FAIL rx_then_tx: writes=%0d rx_valid=%b rx_data=0x%02h required 3/1/0x3c",
                     wq.size() - w0, rx_valid, rx_data);
        end
        if (wq.size() >= w0 + 3) begin
            total++;
            if (wq[w0+2] !== {3'd0, 8'h26}) begin
                bad++;
                $display("FAIL tx_after_rx: got 0x%03h required 0x026", wq[w0+2]);
            end
        end
        tx_enable = 1'b0;
        rx_ready  = 1'b1;
        wait_cycles(10);
        rx_ready = 1'b0;
    endtask

    task automatic test_err_flags();
        int p0;
        int n;
        logic [3:0] exp_flags;
`ifdef UART_BUS_MASTER_ERR_EN
        exp_flags = 4'b0110;
`else
        exp_flags = 4'b0000;
`endif
        p0 = rd5;
        lsr_val = 8'h0C;
        n = 0;
        while (rd5 == p0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lsr_val = 8'h00;
        wait_cycles(40);
        total++;
        if (err_flags !== exp_flags) begin
            bad++;
            $display("FAIL err_sticky: err_flags=%b required %b", err_flags, exp_flags);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wait_cycles(2);
        total++;
        if (err_flags !== 4'b0000) begin
            bad++;
            $display("FAIL err_clear: err_flags=%b required 0000", err_flags);
        end
    endtask

    task automatic test_reset_mid_tx();
        int w0;
        int r0;
        int n;
        logic [10:0] e [5];
        w0 = wq.size();
        lsr_val   = 8'h20;
        tx_count  = 33;
        tx_enable = 1'b1;
        n = 0;
        while (wq.size() < w0 + 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b0;
        #1;
        total++;
        if ({bus_wr, bus_rd, init_done, tx_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async: wr=%b rd=%b init_done=%b tx_ready=%b required all 0",
                     bus_wr, bus_rd, init_done, tx_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        w0 = wq.size();
        r0 = rd5;
        wait_cycles(100);
        total++;
        if (wq.size() != w0 || rd5 != r0 || init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: writes=%0d lsr_reads=%0d init_done=%b required 0/0/0",
                     wq.size() - w0, rd5 - r0, init_done);
        end
        lsr_val = 8'h00;
        e[0] = {3'd3, 8'h9B};
        e[1] = {3'd0, 8'h01};
        e[2] = {3'd1, 8'h00};
        e[3] = {3'd3, 8'h1B};
        e[4] = {3'd2, 8'hC1};
        check_init("reinit", 16'h0001, 8'h1B, 8'hC1, e);
        tx_enable = 1'b0;
    endtask

    task automatic test_protocol();
        total++;
        if (proto_errs != 0) begin
            bad++;
            $display("FAIL bus_protocol: violations=%0d required 0", proto_errs);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            tx_bytes[i] = 8'h10 + 8'(i);
        test_reset();
        test_init();
        test_tx_credits();
        test_rx_hold();
        test_rx_priority();
        test_err_flags();
        test_reset_mid_tx();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
